// File: rtl/mbe_rad4_pkg.sv
// Shared widths and types for the radix-4 Modified Booth mantissa multiplier.
package mbe_rad4_pkg;

    localparam int A_W    = 11;
    localparam int B_W    = 11;
    localparam int P_W    = A_W + B_W;
    localparam int NUM_PP = (B_W + 1) / 2;
    localparam int PP_W   = A_W + 2;

    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } booth_sel_t;

    typedef logic [PP_W-1:0] pp_t;

    // Decode one 3-bit Booth group {b[2i+1], b[2i], b[2i-1]} into select lines.
    // Group 3'b111 is digit 0, so neg is suppressed to avoid a stray +1.
    function automatic booth_sel_t booth_decode(input logic [2:0] grp);
        booth_sel_t sel;
        sel.neg = grp[2] & ~(grp[1] & grp[0]);
        sel.one = grp[1] ^ grp[0];
        sel.two = (grp == 3'b011) || (grp == 3'b100);
        return sel;
    endfunction

endpackage

// File: rtl/mbe_rad4_ppgen.sv
// One Booth partial-product row: select 0 / a / 2a, then one's complement for
// negative digits; the matching +1 is added by the caller at the row's weight.
module mbe_rad4_ppgen
    import mbe_rad4_pkg::*;
(
    input  logic [2:0]     grp,
    input  logic [A_W-1:0] mantissa_a,
    output pp_t            pp,
    output logic           neg
);

    booth_sel_t sel;
    pp_t        mag;

    always_comb begin
        sel = booth_decode(grp);
        mag = '0;
        if (sel.one) begin
            mag = {2'b00, mantissa_a};
        end else if (sel.two) begin
            mag = {1'b0, mantissa_a, 1'b0};
        end
        pp  = sel.neg ? ~mag : mag;
        neg = sel.neg;
    end

endmodule

// File: rtl/mbe_rad4_mult_core.sv
// Unsigned A_W x B_W mantissa multiplier: Booth rows, full sign-extended
// summation and one registered output stage.
module mbe_rad4_mult_core
    import mbe_rad4_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [A_W-1:0] mantissa_a,
    input  logic [B_W-1:0] mantissa_b,
    output logic           out_valid,
    output logic [P_W-1:0] product
);

    // Zero pad on top keeps the last digit non-negative; zero below is b[-1].
    logic [B_W+1:0] b_ext;
    assign b_ext = {1'b0, mantissa_b, 1'b0};

    pp_t            pp   [NUM_PP];
    logic           neg  [NUM_PP];
    logic [P_W-1:0] term [NUM_PP];
    logic [P_W-1:0] corr [NUM_PP];
    logic [P_W-1:0] sum;
    logic [P_W-1:0] product_reg;
    logic           out_valid_reg;

    for (genvar gi = 0; gi < NUM_PP; gi++) begin : g_pp
        mbe_rad4_ppgen u_ppgen (
            .grp        (b_ext[2*gi+2 : 2*gi]),
            .mantissa_a (mantissa_a),
            .pp         (pp[gi]),
            .neg        (neg[gi])
        );

        logic [P_W-1:0] pp_ext;
        assign pp_ext   = {{(P_W-PP_W){pp[gi][PP_W-1]}}, pp[gi]};
        assign term[gi] = pp_ext << (2 * gi);
        assign corr[gi] = {{(P_W-1){1'b0}}, neg[gi]} << (2 * gi);
    end

    // Wrap-around modulo 2^P_W is intended: the true product always fits.
    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_PP; i++) begin
            sum = sum + term[i] + corr[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            product_reg   <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= in_valid;
            if (in_valid) begin
                product_reg <= sum;
            end
        end
    end

    assign product   = product_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_mbe_rad4_mult_core.sv
// Scoreboard bench for mbe_rad4_mult_core: expected products queued at drive
// time, popped and compared one edge later.
module tb_mbe_rad4_mult_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [10:0] mantissa_a;
    logic [10:0] mantissa_b;
    logic        out_valid;
    logic [21:0] product;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [21:0] sb [$];
    logic [21:0] last_exp;

    mbe_rad4_mult_core dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .mantissa_a (mantissa_a),
        .mantissa_b (mantissa_b),
        .out_valid  (out_valid),
        .product    (product)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle (called just after a rising edge), then check just after the next one.
    task automatic cycle(input logic v, input int a, input int b, input string tag);
        logic [21:0] exp;
        in_valid   = v;
        mantissa_a = 11'(a);
        mantissa_b = 11'(b);
        if (v) sb.push_back(22'(a * b));
        @(posedge clk);
        #1;
        if (v) begin
            exp      = sb.pop_front();
            last_exp = exp;
            check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
            check_eq({tag, "_prod"}, 32'(product), 32'(exp));
            $display("txn %s a=%0d b=%0d product=%0d exp=%0d", tag, a, b, product, exp);
        end else begin
            check_eq({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
            check_eq({tag, "_hold_prod"}, 32'(product), 32'(last_exp));
            $display("txn %s idle product=%0d", tag, product);
        end
    endtask

    initial begin
        int ra, rb;
        rst        = 1'b1;
        in_valid   = 1'b0;
        mantissa_a = '0;
        mantissa_b = '0;
        last_exp   = '0;
        #2;
        check_eq("reset_prod", 32'(product), 32'd0);
        check_eq("reset_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        cycle(1'b1, 6, 6, "pre_rst");

        // Async reset with a=5,b=7 pending: must clear without a clock edge.
        in_valid   = 1'b1;
        mantissa_a = 11'd5;
        mantissa_b = 11'd7;
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst_prod", 32'(product), 32'd0);
        check_eq("async_rst_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check_eq("rst_held_prod", 32'(product), 32'd0);
        check_eq("rst_held_valid", 32'(out_valid), 32'd0);
        rst      = 1'b0;
        last_exp = '0;
        sb.delete();
        cycle(1'b1, 5, 7, "post_rst");

        cycle(1'b1, 0, 0, "c00");
        cycle(1'b1, 0, 2047, "c0max");
        cycle(1'b1, 2047, 0, "cmax0");
        cycle(1'b1, 1, 2047, "c1max");
        cycle(1'b1, 2047, 1, "cmax1");
        cycle(1'b1, 2047, 2047, "cmaxmax");
        cycle(1'b1, 1024, 1365, "booth_pm1");
        cycle(1'b1, 2047, 1638, "booth_pm2");

        cycle(1'b1, 3, 4, "tp0");
        cycle(1'b1, 100, 200, "tp1");
        cycle(1'b1, 1024, 1024, "tp2");

        cycle(1'b1, 9, 9, "hold_src");
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 2047, 2047, "hold");
        end

        for (int k = 0; k < 10000; k++) begin
            ra = int'($urandom_range(0, 2047));
            rb = int'($urandom_range(0, 2047));
            cycle(($urandom_range(0, 9) != 0), ra, rb, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
